// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the operation codes decoded from the EX stage, the FSM state
// encoding, and small decode helpers used by the top level.
package mdu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // True for the four ops that launch an iterative computation.
    function automatic logic is_start_op(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the ops whose operands are two's complement.
    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // True for the two divide flavours.
    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Connection between the EX stage and the multiply/divide unit.
// The pipeline side drives the request and operands; the unit returns
// its busy/stall/done status together with the architectural HI/LO.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    import mdu_pkg::*;

    logic              req;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              flush;
    logic              busy;
    logic              stall;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output req, op, a, b, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  req, op, a, b, flush,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: shift-add with the multiplier held in the low half of the
// accumulator. Divide: restoring shift-subtract with the dividend held in
// the low half and the partial remainder building up in the high half.
module muldiv_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Compute both step flavours and select the one for the current mode.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        part_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits     = (part_rem >= {1'b0, operand});
        diff     = part_rem[WIDTH-1:0] - operand;
        acc_next = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (fits) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {part_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit sitting beside the ALU in EX.
// Works on operand magnitudes for WIDTH iterations, then applies the sign
// correction and writes HI/LO with a one-cycle done pulse. MTHI/MTLO write
// HI/LO directly while idle.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          state;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               signed_op;
    logic               start_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (is_div),
        .acc_next (acc_next)
    );

    // Decode the incoming request and form operand magnitudes and the sign-corrected results.
    always_comb begin
        signed_op = is_signed_op(bus.op);
        start_div = is_div_op(bus.op);
        a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        prod_fix  = neg_main ? -acc : acc;
        quot_fix  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM with iteration counter, sign flags and the HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req && !bus.flush) begin
                        if (is_start_op(bus.op)) begin
                            acc      <= {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
                            operand  <= start_div ? b_mag : a_mag;
                            is_div   <= start_div;
                            neg_main <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                                        && (!start_div || (bus.b != '0));
                            neg_rem  <= signed_op && start_div && bus.a[WIDTH-1];
                            counter  <= '0;
                            busy_q   <= 1'b1;
                            state    <= CALC;
                        end else if (bus.op == MD_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == MD_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (counter == CNT_W'(WIDTH)) begin
                        state <= FIX;
                    end else begin
                        acc     <= acc_next;
                        counter <= counter + CNT_W'(1);
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (!bus.flush) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.stall = busy_q & bus.req;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed operations push their hand-computed
// HI/LO into a queue and a monitor pops and compares on every done pulse.
// The stimulus side checks latency, stall, flush and reset behaviour.
module tb_muldiv_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = 34;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   done_seen = 0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset && bus.done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no done pulse", bus.hi, bus.lo);
            end else begin
                mon_e = exp_q.pop_front();
                check_output({mon_e.name, "_hilo"}, {bus.hi, bus.lo}, {mon_e.hi, mon_e.lo});
            end
        end
    end

    // Present one request for a single edge; the unit is idle so stall must stay low.
    task automatic apply_stimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.req = 1'b1;
        bus.op  = op;
        bus.a   = a;
        bus.b   = b;
        #1;
        check_output("idle_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    // Issue an iterative op, count busy cycles, optionally hold an MTLO request while busy.
    task automatic run_op(input string name, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int mtlo_at, input logic [31:0] mtlo_data);
        int cycles;
        bit finished;
        exp_t e;
        e.name = name;
        e.hi   = exp_hi;
        e.lo   = exp_lo;
        exp_q.push_back(e);
        apply_stimulus(op, a, b);
        cycles   = 0;
        finished = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy !== 1'b1) begin
                finished = 1'b1;
                break;
            end
            cycles++;
            if (mtlo_at > 0 && cycles == mtlo_at) begin
                bus.req = 1'b1;
                bus.op  = MD_MTLO;
                bus.a   = mtlo_data;
            end
            if (bus.req) begin
                #1;
                check_output({name, "_stall"}, 64'(bus.stall), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        bus.req = 1'b0;
        if (!finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: busy still high after 100 cycles, required to fall after %0d", name, LAT);
        end else begin
            check_output({name, "_busy_cycles"}, 64'(cycles), 64'(LAT));
            check_output({name, "_done"}, 64'(bus.done), 64'd1);
        end
    endtask

    // Safety net in case the simulation wanders off.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int done_before;
        bus.req   = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_done", 64'(bus.done), 64'd0);
        check_output("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;

        run_op("mult_7_m3",    MD_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 32'd0);
        run_op("multu_max",    MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 32'd0);
        run_op("mult_m1_m1",   MD_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 32'd0);
        run_op("multu_carry",  MD_MULTU, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 32'd0);
        run_op("div_m7_2",     MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 32'd0);
        run_op("divu_5_0",     MD_DIVU,  32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 0, 32'd0);
        run_op("div_m7_0",     MD_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 32'd0);
        run_op("divu_100_7",   MD_DIVU,  32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E, 0, 32'd0);
        run_op("div_overflow", MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 32'd0);

        apply_stimulus(MD_MTHI, 32'h0000_1234, 32'd0);
        check_output("mthi_hilo", {bus.hi, bus.lo}, {32'h0000_1234, 32'h8000_0000});
        check_output("mthi_no_done", 64'(bus.done), 64'd0);
        check_output("mthi_busy", 64'(bus.busy), 64'd0);

        run_op("div_stall", MD_DIV, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 10, 32'h0000_CAFE);
        @(posedge clk);
        #1;
        check_output("stalled_mtlo_dropped", {bus.hi, bus.lo}, {32'h0000_0002, 32'h0000_000E});
        apply_stimulus(MD_MTLO, 32'h0000_CAFE, 32'd0);
        check_output("mtlo_hilo", {bus.hi, bus.lo}, {32'h0000_0002, 32'h0000_CAFE});

        apply_stimulus(MD_MULT, 32'd3, 32'd5);
        check_output("flush_busy_start", 64'(bus.busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_output("flush_busy", 64'(bus.busy), 64'd0);
        done_before = done_seen;
        repeat (40) @(posedge clk);
        #1;
        check_output("flush_no_done", 64'(done_seen), 64'(done_before));
        check_output("flush_hilo", {bus.hi, bus.lo}, {32'h0000_0002, 32'h0000_CAFE});

        apply_stimulus(MD_MULT, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_output("async_reset_busy", 64'(bus.busy), 64'd0);
        check_output("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("post_reset_busy", 64'(bus.busy), 64'd0);
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
